instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It owns the program counter and instruction register, and fetches 8-bit instructions over a req/ack memory port. It pulses the control unit's enable once per instruction, then runs the memory-write or register-writeback phase the opcode requires. It sits between instruction/data memory and the control unit/register file, and is the only block that advances the PC.

---
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns PC and IR, fetches over req/ack, pulses Cu_en, runs MEM or WB phase.
// Latency (zero-wait memory), FETCH entry to FETCH re-entry: 3 cycles ALU, 4 cycles WB or memory write; +1 per ack wait cycle.
// Backpressure: Mem_req is held until Mem_ack; optional wait timeout (define SEQ_TIMEOUT_EN) traps into FAULT.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Mem_req,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [7:0]        Mem_rdata,
  input  logic              Mem_ack,
  output logic              Cu_en,
  output logic [2:0]        Opcode,
  output logic [4:0]        Operand,
  output logic              Reg_we,
  output logic [ADDR_W-1:0] Pc,
  output logic              Busy,
  output logic              Halted,
  output logic              Fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
`ifdef SEQ_TIMEOUT_EN
    S_HALT,
    S_FAULT
`else
    S_HALT
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] operand_addr;

  // Data-write address is the IR operand field fitted to the address width.
  assign operand_addr = ADDR_W'(ir[4:0]);

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  // Last permitted wait cycle: a further cycle without ack gives up.
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Wait counter: counts consecutive no-ack cycles in FETCH/MEM, zero on any state change.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH || state == S_MEM) && state_nxt == state) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IR load and PC advance happen together on the fetch acknowledge edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir <= 8'h00;
      pc <= '0;
    end else if (state == S_FETCH && Mem_ack) begin
      ir <= Mem_rdata;
      pc <= pc + ADDR_W'(1);
    end
  end

  // Next-state selection; EXEC dispatches on the opcode held in IR.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (Mem_ack) state_nxt = S_DECODE;
`ifdef SEQ_TIMEOUT_EN
        else if (wait_expired) state_nxt = S_FAULT;
`endif
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (ir[7:5])
          3'b010, 3'b011, 3'b100, 3'b101: state_nxt = S_MEM;
          3'b110:                         state_nxt = S_WB;
          3'b111:                         state_nxt = S_HALT;
          default:                        state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (Mem_ack) state_nxt = S_FETCH;
`ifdef SEQ_TIMEOUT_EN
        else if (wait_expired) state_nxt = S_FAULT;
`endif
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   if (Start) state_nxt = S_FETCH;
`ifdef SEQ_TIMEOUT_EN
      S_FAULT:  state_nxt = S_FAULT;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state, IR and PC.
  always_comb begin
    Mem_req  = 1'b0;
    Mem_we   = 1'b0;
    Mem_addr = '0;
    Cu_en    = 1'b0;
    Reg_we   = 1'b0;
    Halted   = 1'b0;
    Fault    = 1'b0;
    Busy     = 1'b1;
    case (state)
      S_IDLE:   Busy = 1'b0;
      S_FETCH: begin
        Mem_req  = 1'b1;
        Mem_addr = pc;
      end
      S_DECODE: Cu_en = 1'b1;
      S_MEM: begin
        Mem_req  = 1'b1;
        Mem_we   = 1'b1;
        Mem_addr = operand_addr;
      end
      S_WB:     Reg_we = 1'b1;
      S_HALT: begin
        Halted = 1'b1;
        Busy   = 1'b0;
      end
`ifdef SEQ_TIMEOUT_EN
      S_FAULT: begin
        Fault = 1'b1;
        Busy  = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign Opcode  = ir[7:5];
  assign Operand = ir[4:0];
  assign Pc      = pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and random programs against an instruction-level timing model.
// Latency: each plan entry is one clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: memory wait cycles are chosen per transaction by the bench and folded into the model.
module tb_instr_sequencer;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Mem_req;
  logic              Mem_we;
  logic [ADDR_W-1:0] Mem_addr;
  logic [7:0]        Mem_rdata;
  logic              Mem_ack;
  logic              Cu_en;
  logic [2:0]        Opcode;
  logic [4:0]        Operand;
  logic              Reg_we;
  logic [ADDR_W-1:0] Pc;
  logic              Busy;
  logic              Halted;
  logic              Fault;

  int n_checks = 0;
  int n_fail   = 0;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr),
    .Mem_rdata(Mem_rdata), .Mem_ack(Mem_ack),
    .Cu_en(Cu_en), .Opcode(Opcode), .Operand(Operand), .Reg_we(Reg_we),
    .Pc(Pc), .Busy(Busy), .Halted(Halted), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // One clock of the plan: inputs to apply and outputs expected in that cycle.
  typedef struct {
    logic       ack;
    logic       start;
    logic [7:0] rdata;
    logic       req;
    logic       we;
    logic [4:0] addr;
    logic       cu;
    logic       rwe;
    logic       halt;
    logic       busy;
    logic [4:0] pc;
    logic [7:0] ir;
  } cyc_t;

  cyc_t       plan[$];
  int         m_pc;   // architectural PC of the reference model
  logic [7:0] m_ir;   // last fetched instruction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic ack, input logic start, input logic [7:0] rdata,
                               input logic req, input logic we, input logic [4:0] addr,
                               input logic cu, input logic rwe, input logic halt, input logic busy);
    cyc_t c;
    c.ack = ack; c.start = start; c.rdata = rdata;
    c.req = req; c.we = we; c.addr = addr;
    c.cu = cu; c.rwe = rwe; c.halt = halt; c.busy = busy;
    c.pc = 5'(m_pc); c.ir = m_ir;
    plan.push_back(c);
  endfunction

  // First cycle of a run: sequencer parked in IDLE or HALT, Start raised.
  function automatic void plan_begin(input logic from_halt);
    plan.delete();
    push(rb(), 1'b1, 8'($urandom), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, from_halt, 1'b0);
  endfunction

  // Expected cycles of one instruction: wf fetch waits, wm data-write waits,
  // k idle HALT cycles, then optionally a HALT cycle with Start to resume.
  function automatic void plan_instr(input logic [7:0] instr, input int wf, input int wm,
                                     input int k, input logic resume);
    for (int i = 0; i <= wf; i++)
      push(i == wf, rb(), (i == wf) ? instr : 8'($urandom),
           1'b1, 1'b0, 5'(m_pc), 1'b0, 1'b0, 1'b0, 1'b1);
    m_pc = (m_pc + 1) % 32;
    m_ir = instr;
    push(rb(), rb(), 8'($urandom), 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(rb(), rb(), 8'($urandom), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    case (instr[7:5])
      3'b010, 3'b011, 3'b100, 3'b101:
        for (int i = 0; i <= wm; i++)
          push(i == wm, rb(), 8'($urandom), 1'b1, 1'b1, instr[4:0], 1'b0, 1'b0, 1'b0, 1'b1);
      3'b110:
        push(1'b1, rb(), 8'($urandom), 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      3'b111: begin
        for (int i = 0; i < k; i++)
          push(rb(), 1'b0, 8'($urandom), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (resume)
          push(rb(), 1'b1, 8'($urandom), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      default: ;
    endcase
  endfunction

  // Pad with ALU-only instructions until the model PC reaches target.
  function automatic void fill_to(input int target);
    logic [7:0] r;
    while (m_pc != target) begin
      r = 8'($urandom);
      r[7:6] = 2'b00;
      plan_instr(r, $urandom_range(0, 2), 0, 0, 1'b0);
    end
  endfunction

  // Apply the plan cycle by cycle, comparing all outputs before driving inputs.
  task automatic run_plan(input string name);
    logic [24:0] ev, ov;
    foreach (plan[i]) begin
      ev = {plan[i].req, plan[i].we, plan[i].req ? plan[i].addr : 5'd0, plan[i].cu,
            plan[i].rwe, plan[i].halt, plan[i].busy, 1'b0, plan[i].pc, plan[i].ir};
      ov = {Mem_req, Mem_we, Mem_req ? Mem_addr : 5'd0, Cu_en, Reg_we, Halted, Busy,
            Fault, Pc, Opcode, Operand};
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs {req,we,addr,cu,rwe,halt,busy,fault,pc,ir} got %h expected %h",
                 name, i, ov, ev);
      end
      Mem_ack   = plan[i].ack;
      Start     = plan[i].start;
      Mem_rdata = plan[i].rdata;
      @(posedge Clk); #1;
    end
    Mem_ack = 1'b0;
    Start   = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Mem_ack = 1'b0; Mem_rdata = 8'h00;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    n_checks++;
    if ({Mem_req, Mem_we, Mem_addr, Cu_en, Reg_we, Halted, Busy, Fault, Pc, Opcode, Operand} !== 25'd0) begin
      n_fail++; $display("FAIL reset_idle: outputs nonzero after reset, Pc=%0d Busy=%b", Pc, Busy);
    end
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    n_checks++;
    if ({Mem_req, Mem_we, Mem_addr, Busy} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_fetch_entry: req=%b we=%b addr=%0d busy=%b, expected 1 0 0 1",
                         Mem_req, Mem_we, Mem_addr, Busy);
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    n_checks++;
    if ({Mem_req, Mem_we, Mem_addr, Cu_en, Reg_we, Halted, Busy, Fault, Pc, Opcode, Operand} !== 25'd0) begin
      n_fail++; $display("FAIL reset_mid_request: Mem_req=%b Pc=%0d Busy=%b, expected all zero", Mem_req, Pc, Busy);
    end
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    n_checks++;
    if ({Mem_req, Busy, Pc} !== {1'b0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_release_idle: Mem_req=%b Busy=%b Pc=%0d, expected 0 0 0", Mem_req, Busy, Pc);
    end
    m_pc = 0;
    m_ir = 8'h00;
  endtask

  task automatic test_alu_basic();
    plan_begin(1'b0);
    plan_instr(8'h01, 0, 0, 0, 1'b0);
    plan_instr(8'hE0, 0, 0, 2, 1'b0);
    run_plan("alu_basic");
  endtask

  task automatic test_reg_write_mem_wait();
    plan_begin(1'b1);
    plan_instr(8'hC3, 0, 0, 0, 1'b0);
    plan_instr(8'h45, 0, 3, 0, 1'b0);
    plan_instr(8'hE0, 1, 0, 2, 1'b0);
    run_plan("reg_write_mem_wait");
  endtask

  task automatic test_halt_resume();
    plan_begin(1'b1);
    fill_to(7);
    plan_instr(8'hE0, 0, 0, 3, 1'b0);
    run_plan("halt_at_7");
  endtask

  task automatic test_pc_wrap();
    plan_begin(1'b1);
    fill_to(31);
    plan_instr(8'hC3, 0, 0, 0, 1'b0);
    plan_instr(8'hE0, 0, 0, 2, 1'b0);
    run_plan("pc_wrap");
  endtask

  task automatic test_random();
    logic [7:0] instr;
    for (int r = 0; r < 8; r++) begin
      plan_begin(1'b1);
      for (int n = 0; n < int'($urandom_range(8, 20)); n++) begin
        instr = 8'($urandom);
        plan_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end
      plan_instr(8'hE0 | 8'($urandom_range(0, 31)), $urandom_range(0, 3), 0, 2, 1'b0);
      run_plan("random_program");
    end
  endtask

  task automatic test_timeout();
`ifdef SEQ_TIMEOUT_EN
    int   reqs = 0;
    logic got  = 1'b0;
    int   pc0  = m_pc;
    Mem_ack = 1'b0;
    Start   = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (Fault) got = 1'b1;
      else begin
        if (Mem_req) reqs++;
        @(posedge Clk); #1;
      end
    end
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL timeout_fault: Fault never rose within 40 cycles");
    end
    n_checks++;
    if (reqs !== TIMEOUT) begin
      n_fail++; $display("FAIL timeout_wait_cycles: got %0d request cycles, expected %0d", reqs, TIMEOUT);
    end
    n_checks++;
    if ({Mem_req, Busy, Halted, Pc} !== {1'b0, 1'b0, 1'b0, 5'(pc0)}) begin
      n_fail++; $display("FAIL timeout_outputs: req=%b busy=%b halted=%b Pc=%0d, expected 0 0 0 %0d",
                         Mem_req, Busy, Halted, Pc, pc0);
    end
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b0;
    n_checks++;
    if ({Fault, Mem_req, Busy} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_start_ignored: Fault=%b req=%b busy=%b, expected 1 0 0", Fault, Mem_req, Busy);
    end
    Reset = 1'b1;
    #2;
    n_checks++;
    if ({Fault, Pc} !== 6'd0) begin
      n_fail++; $display("FAIL timeout_reset_clears: Fault=%b Pc=%0d, expected 0 0", Fault, Pc);
    end
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    m_pc = 0;
    m_ir = 8'h00;
`endif
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_reg_write_mem_wait();
    test_halt_resume();
    test_pc_wrap();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
